piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the sipo deserializer and drives its si input.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock.
- Provides frame strobes (so_valid, so_last) so the downstream sipo can align word boundaries.
- Supports back-to-back words with no idle bit between frames.

Parameters:
- WIDTH, 4, data word width in bits (≥2); matches the sipo po width.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 first.
- CNT_W, $clog2(WIDTH), width of the internal bit counter (derived, not overridden).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  shift enable (bit-rate tick); the frame only advances on cycles where en=1.
- in_data  in  WIDTH  parallel word to serialize.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle (combinational from state, counter and en).
- so  out  1  serial data out (to sipo si); registered.
- so_valid  out  1  so carries a frame bit; registered.
- so_last  out  1  so carries the final bit of the frame; registered.
- busy  out  1  frame in progress (state==SHIFT).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, bit_cnt=0, so=0, so_valid=0, so_last=0, busy=0.
- Reset effect is immediate, independent of clk. The first action after release is on the first rising edge with rst=1.
- FSM has two states: IDLE and SHIFT.
- in_ready = (state==IDLE) | (state==SHIFT & so_last & en). It never depends on in_valid.
- Accept event = in_valid & in_ready at a rising edge. Only then is in_data sampled; in_data is ignored at all other times.
- IDLE:
  - On accept: load the shift register with in_data, bit_cnt=0, go to SHIFT.
  - so is driven with the first bit (in_data[WIDTH-1] if MSB_FIRST, else in_data[0]); so_valid=1; so_last=0.
  - Latency: the first bit is visible in the cycle after the accepting edge.
  - en is not required to accept in IDLE.
  - Without accept: so=0, so_valid=0, so_last=0.
- SHIFT, on an edge with en=1:
  - If bit_cnt < WIDTH-1: bit_cnt+1, shift the register one position toward the output end, so=next bit, so_last=(bit_cnt+1 == WIDTH-1).
  - If bit_cnt == WIDTH-1 (last bit on so) and accept: reload exactly as in IDLE and stay in SHIFT. This is back-to-back operation: no gap, and so_valid stays 1.
  - If bit_cnt == WIDTH-1 and no accept: go to IDLE; so=0, so_valid=0, so_last=0.
- SHIFT, on an edge with en=0: all registers hold, so each bit stretches by one cycle; in_ready=0.
- A frame with en held high occupies exactly WIDTH consecutive so_valid cycles.
- in_valid asserted while busy and not in the last-bit cycle: no effect. The word is not consumed and the source must hold it.
- Reset mid-frame: the frame is dropped and no partial bits resume. The next accept starts a clean frame at bit 0.
- bit_cnt never exceeds WIDTH-1; there is no wrap except through reload or return to IDLE.

Decomposition:
- Shared package (serdes_pkg): state encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1, and the default WIDTH=4. The sipo and its testbench use the same constant.
- No sub-module is needed. The shift register, counter and FSM are inline in one module of roughly 120–160 lines.

Test Plan:
1. Reset with rst=0 and in_valid=1 → so=0, so_valid=0, so_last=0, busy=0, in_ready=1 immediately. No accept until rst=1.
2. MSB_FIRST=1, en=1, accept 4'b1011 at edge N → so=1,0,1,1 in cycles N+1..N+4; so_last only at N+4; in_ready=0 at N+1..N+3 and 1 at N+4; so_valid=0 at N+5.
3. Back-to-back: in_valid held with 4'b1111 then 4'b0101 → eight consecutive so_valid cycles with so=1,1,1,1,0,1,0,1; so_last at bits 4 and 8; second word consumed in the first word's last-bit cycle.
4. en low for 3 cycles after the second bit of 4'b1001 → so held at 0 for 4 cycles total; frame is WIDTH+3 cycles; bit values unchanged.
5. rst pulsed low mid-frame (after 2 bits of 4'b1100) → outputs 0 asynchronously. After release, accept 4'b0011 → so=0,0,1,1 with no residue.
6. MSB_FIRST=0, accept 4'b1011 → so=1,1,0,1. in_valid with a new word during bits 1–3 → ignored; word accepted only on the so_last cycle.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared definitions for the piso/sipo serializer pair: FSM state encoding and
// the default word width that both ends of the link agree on.
package serdes_pkg;

  localparam int SERDES_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } serdes_state_e;

endpackage : serdes_pkg

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes a word over valid/ready and shifts it out
// one bit per en tick, with so_valid/so_last framing and back-to-back reloads.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = SERDES_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  serdes_state_e    state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;

  // The output end of the shift register is the serial pin itself, so so is a
  // flop output; the register is cleared whenever the frame ends to force so=0.
  assign so = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

  assign in_ready = (state == ST_IDLE) | ((state == ST_SHIFT) & so_last & en);
  assign accept   = in_valid & in_ready;
  assign busy     = (state == ST_SHIFT);

  always_comb begin
    sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  end

  // NOTE: asynchronous reset in the sensitivity list, and <= for every state
  // register so all flops update from pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      sreg     <= '0;
      bit_cnt  <= '0;
      so_valid <= 1'b0;
      so_last  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_SHIFT;
            sreg     <= in_data;
            bit_cnt  <= '0;
            so_valid <= 1'b1;
            so_last  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (en) begin
            if (bit_cnt != LAST_CNT) begin
              bit_cnt <= bit_cnt + 1'b1;
              sreg    <= sreg_shifted;
              so_last <= ((bit_cnt + 1'b1) == LAST_CNT);
            end else if (accept) begin
              // Reload in the last-bit cycle: next frame starts with no gap.
              sreg     <= in_data;
              bit_cnt  <= '0;
              so_valid <= 1'b1;
              so_last  <= 1'b0;
            end else begin
              state    <= ST_IDLE;
              sreg     <= '0;
              bit_cnt  <= '0;
              so_valid <= 1'b0;
              so_last  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : piso_serializer
